// File: rtl/intersection_monitor_if.sv
// rtl/intersection_monitor_if.sv - light/sensor/queue bundle between light controller side and intersection monitor
//
// Purpose: groups the light codes, car arrival pulses, error clear and all
//          monitor observables into one interface.
// Modports:
//   master - light controller / bench side: drives la, lb, arrive_a, arrive_b,
//            clr_err (and m when INTERSECTION_PARADE_CHECK_EN is defined),
//            observes ta, tb, queue_a, queue_b, served_a, served_b, err.
//   slave  - intersection_monitor side, opposite directions.
// Macro: INTERSECTION_PARADE_CHECK_EN adds the 1-bit parade-mode signal m.

interface intersection_monitor_if #(
  parameter int QW = 4,
  parameter int CW = 8
);
  logic [1:0]    la;
  logic [1:0]    lb;
  logic          arrive_a;
  logic          arrive_b;
  logic          clr_err;
`ifdef INTERSECTION_PARADE_CHECK_EN
  logic          m;
`endif
  logic          ta;
  logic          tb;
  logic [QW-1:0] queue_a;
  logic [QW-1:0] queue_b;
  logic [CW-1:0] served_a;
  logic [CW-1:0] served_b;
  logic [4:0]    err;

  modport master (
`ifdef INTERSECTION_PARADE_CHECK_EN
    output m,
`endif
    output la, lb, arrive_a, arrive_b, clr_err,
    input  ta, tb, queue_a, queue_b, served_a, served_b, err
  );

  modport slave (
`ifdef INTERSECTION_PARADE_CHECK_EN
    input  m,
`endif
    input  la, lb, arrive_a, arrive_b, clr_err,
    output ta, tb, queue_a, queue_b, served_a, served_b, err
  );
endinterface

// File: rtl/intersection_monitor.sv
// rtl/intersection_monitor.sv - two-street traffic light consumer: car queues, sensors and protocol checker
//
// Purpose: models one car queue per street (arrival pulses in, one departure
//          per cycle while green), drives the street sensors from the queues
//          and flags light-sequence protocol violations in sticky error bits.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-low reset
//   bus    - intersection_monitor_if.slave:
//              la/lb     light codes (00 green, 01 yellow, 10 red, 11 illegal)
//              arrive_*  one car arrives on that street this cycle
//              clr_err   zero the error flags
//              m         parade mode (only with INTERSECTION_PARADE_CHECK_EN)
//              ta/tb     sensor, high while that queue is non-empty
//              queue_*   cars waiting, served_* cars departed (wrapping)
//              err       [0] conflict [1] illegal code [2] illegal transition
//                        [3] queue overflow [4] parade violation
// Macro: INTERSECTION_PARADE_CHECK_EN enables the parade check (err[4]);
//        undefined, err[4] is constant 0.

module intersection_monitor #(
  parameter int QW = 4,
  parameter int CW = 8
) (
  input logic                   clk,
  input logic                   reset,
  intersection_monitor_if.slave bus
);

  localparam logic [1:0]    GREEN  = 2'b00;
  localparam logic [1:0]    YELLOW = 2'b01;
  localparam logic [1:0]    RED    = 2'b10;
  localparam logic [1:0]    BAD    = 2'b11;
  localparam logic [QW-1:0] Q_ONE  = QW'(1);
  localparam logic [QW-1:0] Q_MAX  = '1;
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [QW-1:0] queue_a_r, queue_b_r;
  logic [CW-1:0] served_a_r, served_b_r;
  logic [4:0]    err_r;
  logic [1:0]    prev_la, prev_lb;
  logic          prev_valid;

  logic          dep_a, dep_b;
  logic          ovf_a, ovf_b;
  logic          parade_viol;
  logic [4:0]    viol;

  // Legal per-street steps: G->G, G->Y, Y->R, R->R, R->G. Everything else,
  // including Y->Y and any step touching code 11, is a violation.
  function automatic logic legal_step(input logic [1:0] p, input logic [1:0] c);
    case (p)
      GREEN:   legal_step = (c == GREEN) || (c == YELLOW);
      YELLOW:  legal_step = (c == RED);
      RED:     legal_step = (c == RED) || (c == GREEN);
      default: legal_step = 1'b0;
    endcase
  endfunction

  always_comb begin
    // An illegal code is never GREEN, so the queue on that street holds.
    dep_a = (bus.la == GREEN) && (queue_a_r != '0);
    dep_b = (bus.lb == GREEN) && (queue_b_r != '0);
    ovf_a = bus.arrive_a && !dep_a && (queue_a_r == Q_MAX);
    ovf_b = bus.arrive_b && !dep_b && (queue_b_r == Q_MAX);

`ifdef INTERSECTION_PARADE_CHECK_EN
    parade_viol = bus.m && prev_valid &&
                  (((prev_lb == GREEN) && (bus.lb != GREEN)) || (bus.la == GREEN));
`else
    parade_viol = 1'b0;
`endif

    viol    = '0;
    viol[0] = (bus.la != RED) && (bus.lb != RED);
    viol[1] = (bus.la == BAD) || (bus.lb == BAD);
    viol[2] = prev_valid && (!legal_step(prev_la, bus.la) || !legal_step(prev_lb, bus.lb));
    viol[3] = ovf_a || ovf_b;
    viol[4] = parade_viol;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      queue_a_r  <= '0;
      queue_b_r  <= '0;
      served_a_r <= '0;
      served_b_r <= '0;
      err_r      <= '0;
      prev_la    <= RED;
      prev_lb    <= RED;
      prev_valid <= 1'b0;
    end else begin
      // Street A: an arrival and a departure in the same cycle cancel.
      if (bus.arrive_a && !dep_a) begin
        if (queue_a_r != Q_MAX) queue_a_r <= queue_a_r + Q_ONE;
      end else if (dep_a) begin
        if (!bus.arrive_a) queue_a_r <= queue_a_r - Q_ONE;
        served_a_r <= served_a_r + C_ONE;
      end

      if (bus.arrive_b && !dep_b) begin
        if (queue_b_r != Q_MAX) queue_b_r <= queue_b_r + Q_ONE;
      end else if (dep_b) begin
        if (!bus.arrive_b) queue_b_r <= queue_b_r - Q_ONE;
        served_b_r <= served_b_r + C_ONE;
      end

      // clr_err takes priority over anything detected on the same edge.
      if (bus.clr_err) err_r <= '0;
      else             err_r <= err_r | viol;

      prev_la    <= bus.la;
      prev_lb    <= bus.lb;
      prev_valid <= 1'b1;
    end
  end

  assign bus.ta       = (queue_a_r != '0);
  assign bus.tb       = (queue_b_r != '0);
  assign bus.queue_a  = queue_a_r;
  assign bus.queue_b  = queue_b_r;
  assign bus.served_a = served_a_r;
  assign bus.served_b = served_b_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_intersection_monitor.sv
// tb/tb_intersection_monitor.sv - scoreboard testbench for intersection_monitor

module tb_intersection_monitor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  intersection_monitor_if #(.QW(4), .CW(8)) ifc ();

  intersection_monitor #(.QW(4), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  typedef struct packed {
    logic [3:0] qa;
    logic [3:0] qb;
    logic [7:0] sa;
    logic [7:0] sb;
    logic [4:0] err;
    logic       ta;
    logic       tb;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference state
  int       m_qa, m_qb, m_sa, m_sb;
  logic [4:0] m_err;
  logic [1:0] m_pla, m_plb;
  bit       m_pv;

  function automatic bit step_ok(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b0000, 4'b0001, 4'b0110, 4'b1010, 4'b1000: step_ok = 1'b1;
      default:                                     step_ok = 1'b0;
    endcase
  endfunction

  // Advance the reference model by one clock with the given inputs.
  task automatic model_step(input logic rst, input logic [1:0] a, input logic [1:0] b,
                            input logic arr_a, input logic arr_b, input logic clr,
                            input logic mm);
    logic [4:0] v;
    bit go_a, go_b;
    if (!rst) begin
      m_qa = 0; m_qb = 0; m_sa = 0; m_sb = 0;
      m_err = 5'b0; m_pla = 2'b10; m_plb = 2'b10; m_pv = 0;
      return;
    end
    v = 5'b0;
    go_a = (a == 2'b00) && (m_qa > 0);
    go_b = (b == 2'b00) && (m_qb > 0);
    if (a != 2'b10 && b != 2'b10) v[0] = 1'b1;
    if (a == 2'b11 || b == 2'b11) v[1] = 1'b1;
    if (m_pv && !(step_ok(m_pla, a) && step_ok(m_plb, b))) v[2] = 1'b1;
    m_qa = m_qa + (arr_a ? 1 : 0) - (go_a ? 1 : 0);
    m_qb = m_qb + (arr_b ? 1 : 0) - (go_b ? 1 : 0);
    if (m_qa > 15) begin m_qa = 15; v[3] = 1'b1; end
    if (m_qb > 15) begin m_qb = 15; v[3] = 1'b1; end
    if (go_a) m_sa = (m_sa + 1) % 256;
    if (go_b) m_sb = (m_sb + 1) % 256;
`ifdef INTERSECTION_PARADE_CHECK_EN
    if (mm && m_pv && ((m_plb == 2'b00 && b != 2'b00) || a == 2'b00)) v[4] = 1'b1;
`else
    if (mm) v[4] = 1'b0;
`endif
    m_err = clr ? 5'b0 : (m_err | v);
    m_pla = a; m_plb = b; m_pv = 1;
  endtask

  // Drive one cycle of stimulus, queue the expected outcome, then compare it
  // against the DUT one time unit after the edge.
  task automatic drive(input logic rst, input logic [1:0] a, input logic [1:0] b,
                       input logic arr_a, input logic arr_b, input logic clr,
                       input logic mm);
    exp_t e;
    reset        = rst;
    ifc.la       = a;
    ifc.lb       = b;
    ifc.arrive_a = arr_a;
    ifc.arrive_b = arr_b;
    ifc.clr_err  = clr;
`ifdef INTERSECTION_PARADE_CHECK_EN
    ifc.m        = mm;
`endif
    model_step(rst, a, b, arr_a, arr_b, clr, mm);
    e.qa = 4'(m_qa); e.qb = 4'(m_qb); e.sa = 8'(m_sa); e.sb = 8'(m_sb);
    e.err = m_err; e.ta = (m_qa != 0); e.tb = (m_qb != 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_total++; if (ifc.queue_a  !== e.qa)  $display("FAIL sb_queue_a got %0d want %0d", ifc.queue_a, e.qa);   else n_pass++;
    n_total++; if (ifc.queue_b  !== e.qb)  $display("FAIL sb_queue_b got %0d want %0d", ifc.queue_b, e.qb);   else n_pass++;
    n_total++; if (ifc.served_a !== e.sa)  $display("FAIL sb_served_a got %0d want %0d", ifc.served_a, e.sa); else n_pass++;
    n_total++; if (ifc.served_b !== e.sb)  $display("FAIL sb_served_b got %0d want %0d", ifc.served_b, e.sb); else n_pass++;
    n_total++; if (ifc.err      !== e.err) $display("FAIL sb_err got %b want %b", ifc.err, e.err);           else n_pass++;
    n_total++; if (ifc.ta       !== e.ta)  $display("FAIL sb_ta got %b want %b", ifc.ta, e.ta);              else n_pass++;
    n_total++; if (ifc.tb       !== e.tb)  $display("FAIL sb_tb got %b want %b", ifc.tb, e.tb);              else n_pass++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) drive(1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++; if (ifc.queue_a !== 4'd0 || ifc.served_a !== 8'd0 || ifc.err !== 5'b0 || ifc.ta !== 1'b0)
      $display("FAIL reset_hold got q=%0d s=%0d err=%b ta=%b want 0/0/00000/0", ifc.queue_a, ifc.served_a, ifc.err, ifc.ta);
    else n_pass++;
    drive(1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++; if (ifc.queue_a !== 4'd0 || ifc.served_a !== 8'd0 || ifc.err !== 5'b0 || ifc.ta !== 1'b0)
      $display("FAIL reset_release got q=%0d s=%0d err=%b ta=%b want 0/0/00000/0", ifc.queue_a, ifc.served_a, ifc.err, ifc.ta);
    else n_pass++;
  endtask

  task automatic test_queue_flow();
    logic [3:0] want_q [4];
    want_q = '{4'd2, 4'd1, 4'd0, 4'd0};
    drive(1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++; if (ifc.queue_a !== 4'd3 || ifc.ta !== 1'b1)
      $display("FAIL flow_fill got q=%0d ta=%b want 3/1", ifc.queue_a, ifc.ta); else n_pass++;
    drive(1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      n_total++; if (ifc.queue_a !== want_q[i] || ifc.ta !== (want_q[i] != 4'd0))
        $display("FAIL flow_drain%0d got q=%0d ta=%b want %0d", i, ifc.queue_a, ifc.ta, want_q[i]);
      else n_pass++;
    end
    n_total++; if (ifc.served_a !== 8'd3 || ifc.err !== 5'b0)
      $display("FAIL flow_served got s=%0d err=%b want 3/00000", ifc.served_a, ifc.err); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 15; i++) drive(1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    n_total++; if (ifc.queue_b !== 4'd15 || ifc.err[3] !== 1'b0)
      $display("FAIL ovf_full got q=%0d err=%b want 15/err3=0", ifc.queue_b, ifc.err); else n_pass++;
    drive(1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    n_total++; if (ifc.queue_b !== 4'd15 || ifc.err !== 5'b01000)
      $display("FAIL ovf_set got q=%0d err=%b want 15/01000", ifc.queue_b, ifc.err); else n_pass++;
    drive(1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    n_total++; if (ifc.queue_b !== 4'd15 || ifc.served_b !== 8'd1)
      $display("FAIL ovf_arrdep got q=%0d s=%0d want 15/1", ifc.queue_b, ifc.served_b); else n_pass++;
    drive(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++; if (ifc.err !== 5'b0 || ifc.queue_b !== 4'd14)
      $display("FAIL ovf_clear got err=%b q=%0d want 00000/14", ifc.err, ifc.queue_b); else n_pass++;
  endtask

  task automatic test_sequence_and_clear();
    logic [1:0] seq [5];
    seq = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
    drive(1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, seq[i], 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++; if (ifc.err !== 5'b0) $display("FAIL seq_legal got err=%b want 00000", ifc.err); else n_pass++;
    drive(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++; if (ifc.err !== 5'b00100) $display("FAIL seq_g2r got err=%b want 00100", ifc.err); else n_pass++;
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++; if (ifc.err !== 5'b00101) $display("FAIL seq_conflict got err=%b want 00101", ifc.err); else n_pass++;
    drive(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++; if (ifc.err !== 5'b00111) $display("FAIL seq_illegal got err=%b want 00111", ifc.err); else n_pass++;
    drive(1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++; if (ifc.err !== 5'b0) $display("FAIL clr_legal got err=%b want 00000", ifc.err); else n_pass++;
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++; if (ifc.err !== 5'b0) $display("FAIL clr_wins got err=%b want 00000", ifc.err); else n_pass++;
  endtask

  task automatic test_midop_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    n_total++; if (ifc.queue_a !== 4'd0 || ifc.queue_b !== 4'd0 || ifc.tb !== 1'b0)
      $display("FAIL midop_reset got qa=%0d qb=%0d tb=%b want 0/0/0", ifc.queue_a, ifc.queue_b, ifc.tb);
    else n_pass++;
  endtask

  task automatic test_parade();
    logic [4:0] want;
    drive(1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    n_total++; if (ifc.err !== 5'b0) $display("FAIL parade_hold got err=%b want 00000", ifc.err); else n_pass++;
    drive(1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef INTERSECTION_PARADE_CHECK_EN
    want = 5'b10000;
`else
    want = 5'b00000;
`endif
    n_total++; if (ifc.err !== want) $display("FAIL parade_break got err=%b want %b", ifc.err, want); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    ifc.la = 2'b10; ifc.lb = 2'b10;
    ifc.arrive_a = 1'b0; ifc.arrive_b = 1'b0; ifc.clr_err = 1'b0;
`ifdef INTERSECTION_PARADE_CHECK_EN
    ifc.m = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_queue_flow();
    test_overflow();
    test_sequence_and_clear();
    test_midop_reset();
    test_parade();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/intersection_monitor.md
Name: intersection_monitor

Overview:
- Consumer end of the two-street traffic-light interface: samples light codes la/lb from the light controller and drives the traffic sensors ta/tb.
- Models a car queue per street: arrivals come in as pulses, and one car departs per cycle while that street is green.
- Checks the light sequence for protocol violations and flags them in sticky error bits.
- Used as a bench companion and as an on-chip safety monitor beside the controller.

Parameters:
- QW, 4: width of each queue counter; max queue = 2^QW-1.
- CW, 8: width of each served-car counter; wraps modulo 2^CW.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- la  input  2  street A light: 00 green, 01 yellow, 10 red, 11 illegal
- lb  input  2  street B light, same encoding
- arrive_a  input  1  one car arrives on A this cycle
- arrive_b  input  1  one car arrives on B this cycle
- clr_err  input  1  clears err when high
- ta  output  1  A sensor: high when queue_a != 0
- tb  output  1  B sensor: high when queue_b != 0
- queue_a  output  QW  cars waiting on A
- queue_b  output  QW  cars waiting on B
- served_a  output  CW  cars departed on A
- served_b  output  CW  cars departed on B
- err  output  5  sticky flags: [0] conflict, [1] illegal code, [2] illegal transition, [3] queue overflow, [4] parade violation

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: sampled on posedge clk while low. It forces queue_a/b=0, served_a/b=0, err=0, prev_valid=0, prev_la/prev_lb=10. Consequently ta=tb=0. Reset mid-operation discards all queued cars.
- Per-street queue update, evaluated each posedge:
  - dep = (light==00) && (queue!=0).
  - arrive && !dep: queue+1. If queue is already max, queue holds and err[3] is set.
  - dep && !arrive: queue-1, served+1.
  - arrive && dep: queue unchanged, served+1.
  - Neither: hold.
  - Departure uses the light sampled in the same cycle. Zero added latency on departure.
- ta/tb are combinational from the queue registers, so an arrival is visible on ta one cycle after the arrive pulse.
- served_* wraps from 2^CW-1 to 0 with no flag.
- Conflict check: la!=10 && lb!=10 in the same cycle sets err[0].
- Illegal code: la==11 or lb==11 sets err[1]. That street's queue holds (no departure) for that cycle.
- Transition check: prev_la/prev_lb registers hold the previous cycle's codes. prev_valid goes to 1 after the first sample following reset; transition checks are skipped while prev_valid=0.
  - Legal per street: G->G, G->Y, Y->R, R->R, R->G.
  - Any other change, including Y->Y, G->R, R->Y, or anything to/from 11, sets err[2].
- Error bits are sticky; several may set in one cycle.
- clr_err=1 zeroes err on that edge. If a new violation is detected in the same cycle, clr_err wins; the violation is lost.

Optional Feature:
- Macro: INTERSECTION_PARADE_CHECK_EN.
- Defined: adds input port m (1 bit, parade mode).
  - m=1 && prev_lb==00 && lb!=00 sets err[4]: B must stay green during parade.
  - m=1 && la==00 sets err[4]: A must not be green during parade.
  - Both checks are gated by prev_valid.
- Undefined: port m absent; err[4] tied to 0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with arrive_a=1, la=00 -> queue_a=0, served_a=0, err=00000, ta=0; all remain so on the first cycle after release.
- Queue flow: la=10, lb=00. Pulse arrive_a for 3 cycles -> queue_a=3, ta=1. Then la=00, lb=10 for 4 cycles -> queue_a steps 2,1,0,0; served_a=3; ta=0 after the third departure.
- Simultaneous events and overflow:
  - QW=4, queue_b=15, lb=10, arrive_b=1 -> queue_b stays 15, err[3]=1.
  - Then lb=00 with arrive_b=1 -> queue_b stays 15, served_b+1.
- Sequence legality:
  - la sequence 00,01,10,10,00 with lb opposite-red-legal -> err=0.
  - Injecting la 00->10 -> err[2]=1 next cycle.
  - la=lb=00 -> err[0]=1.
  - lb=11 -> err[1]=1.
- Clear: err=00111, pulse clr_err with legal lights -> err=00000. clr_err coinciding with a conflict -> err=00000.
- Parade (macro defined): m=1, lb held 00 for 5 cycles -> err[4]=0. lb 00->01 while m=1 -> err[4]=1. Macro undefined: same stimulus -> err[4]=0.
